// File: rtl/bram_2048x8_arb.sv
// Two-port arbiter for a shared 2048x8 BRAM: grants up to two requesters per cycle and routes read data back.
// Optional feature macro BRAM_ARB_RR_EN: round-robin scan from a rotating pointer (default: fixed priority, index 0 highest).
module bram_2048x8_arb #(
    parameter int NREQ = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ-1:0]    i_we,
    input  logic [NREQ*11-1:0] i_a,
    input  logic [NREQ*8-1:0]  i_d,
    output logic [NREQ-1:0]    o_gnt,
    output logic [NREQ-1:0]    o_rvalid,
    output logic [NREQ*8-1:0]  o_rdata,
    output logic [10:0]        o_mem_a0,
    output logic [10:0]        o_mem_a1,
    output logic [7:0]         o_mem_d0,
    output logic [7:0]         o_mem_d1,
    output logic               o_mem_we0,
    output logic               o_mem_we1,
    output logic [7:0]         o_mem_wem0,
    output logic [7:0]         o_mem_wem1,
    output logic               o_mem_ce0,
    output logic               o_mem_ce1,
    input  logic [7:0]         i_mem_q0,
    input  logic [7:0]         i_mem_q1
);
    localparam int AW     = 11;
    localparam int DATA_W = 8;
    localparam int IW     = $clog2(NREQ);

    logic [AW-1:0]     w_a_arr [NREQ];
    logic [DATA_W-1:0] w_d_arr [NREQ];

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_unpack
            assign w_a_arr[g] = i_a[g*AW +: AW];
            assign w_d_arr[g] = i_d[g*DATA_W +: DATA_W];
        end
    endgenerate

    logic [IW-1:0] w_start;
    logic [IW-1:0] w_w0;
    logic [IW-1:0] w_w1;
    logic          w_w0_vld;
    logic          w_w1_vld;
    logic          w_same_addr;
    logic          w_any_wr;
    logic          w_g0;
    logic          w_g1;

`ifdef BRAM_ARB_RR_EN
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_last;
    logic [IW-1:0] w_ptr_nxt;
    assign w_start = r_ptr;
`else
    assign w_start = '0;
`endif

    // Stage p0: combinational scan picks the first two requesters in wrap-around order
    always_comb begin
        int            v_sum;
        logic [IW-1:0] v_idx;
        w_w0     = '0;
        w_w1     = '0;
        w_w0_vld = 1'b0;
        w_w1_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            v_sum = int'(w_start) + k;
            if (v_sum >= NREQ) v_sum = v_sum - NREQ;
            v_idx = IW'(v_sum);
            if (i_req[v_idx]) begin
                if (!w_w0_vld) begin
                    w_w0_vld = 1'b1;
                    w_w0     = v_idx;
                end else if (!w_w1_vld) begin
                    w_w1_vld = 1'b1;
                    w_w1     = v_idx;
                end
            end
        end
    end

    // Port 1 backs off when it would touch the same word as port 0 and either side writes
    assign w_same_addr = (w_a_arr[w_w0] == w_a_arr[w_w1]);
    assign w_any_wr    = i_we[w_w0] | i_we[w_w1];
    assign w_g0        = w_w0_vld & ~i_rst;
    assign w_g1        = w_w1_vld & ~(w_same_addr & w_any_wr) & ~i_rst;

    always_comb begin
        o_gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_gnt[i] = (w_g0 && (w_w0 == IW'(i))) || (w_g1 && (w_w1 == IW'(i)));
        end
    end

    assign o_mem_ce0  = w_g0;
    assign o_mem_we0  = w_g0 & i_we[w_w0];
    assign o_mem_a0   = w_g0 ? w_a_arr[w_w0] : '0;
    assign o_mem_d0   = w_g0 ? w_d_arr[w_w0] : '0;
    assign o_mem_wem0 = 8'hFF;

    assign o_mem_ce1  = w_g1;
    assign o_mem_we1  = w_g1 & i_we[w_w1];
    assign o_mem_a1   = w_g1 ? w_a_arr[w_w1] : '0;
    assign o_mem_d1   = w_g1 ? w_d_arr[w_w1] : '0;
    assign o_mem_wem1 = 8'hFF;

`ifdef BRAM_ARB_RR_EN
    always_comb begin
        w_last    = w_g1 ? w_w1 : w_w0;
        w_ptr_nxt = (w_last == IW'(NREQ - 1)) ? '0 : w_last + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_g0) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif

    // Stage p1: read tags remember who owns each port's data on the following cycle
    logic          r_vld0_p1;
    logic          r_vld1_p1;
    logic [IW-1:0] r_idx0_p1;
    logic [IW-1:0] r_idx1_p1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld0_p1 <= 1'b0;
            r_vld1_p1 <= 1'b0;
            r_idx0_p1 <= '0;
            r_idx1_p1 <= '0;
        end else begin
            r_vld0_p1 <= w_g0 & ~i_we[w_w0];
            r_vld1_p1 <= w_g1 & ~i_we[w_w1];
            r_idx0_p1 <= w_w0;
            r_idx1_p1 <= w_w1;
        end
    end

    always_comb begin
        o_rvalid = '0;
        o_rdata  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_vld0_p1 && (r_idx0_p1 == IW'(i))) begin
                o_rvalid[i]                  = 1'b1;
                o_rdata[i*DATA_W +: DATA_W]  = i_mem_q0;
            end else if (r_vld1_p1 && (r_idx1_p1 == IW'(i))) begin
                o_rvalid[i]                  = 1'b1;
                o_rdata[i*DATA_W +: DATA_W]  = i_mem_q1;
            end
        end
    end

endmodule

// File: tb/tb_bram_2048x8_arb.sv
// Self-checking bench for bram_2048x8_arb: directed scenarios plus randomized traffic against a reference model.
module tb_bram_2048x8_arb;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   we  = '0;
    logic [NREQ*11-1:0] a;
    logic [NREQ*8-1:0]  d;
    logic [10:0]       ra [NREQ];
    logic [7:0]        rd [NREQ];

    logic [NREQ-1:0]   gnt, rvalid;
    logic [NREQ*8-1:0] rdata;
    logic [10:0]       mem_a0, mem_a1;
    logic [7:0]        mem_d0, mem_d1, mem_wem0, mem_wem1;
    logic              mem_we0, mem_we1, mem_ce0, mem_ce1;
    logic [7:0]        mem_q0 = '0, mem_q1 = '0;

    logic [7:0]        bram    [2048];
    logic [7:0]        ref_mem [2048];

    int errors = 0;
    int checks = 0;

    int              m_ptr = 0;
    logic [NREQ-1:0] exp_rv = '0;
    logic [NREQ*8-1:0] exp_rd = '0;

    always #5 clk = ~clk;

    always_comb begin
        a = '0;
        d = '0;
        for (int i = 0; i < NREQ; i++) begin
            a[i*11 +: 11] = ra[i];
            d[i*8 +: 8]   = rd[i];
        end
    end

    bram_2048x8_arb #(.NREQ(NREQ)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_a(a), .i_d(d),
        .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
        .o_mem_a0(mem_a0), .o_mem_a1(mem_a1), .o_mem_d0(mem_d0), .o_mem_d1(mem_d1),
        .o_mem_we0(mem_we0), .o_mem_we1(mem_we1), .o_mem_wem0(mem_wem0), .o_mem_wem1(mem_wem1),
        .o_mem_ce0(mem_ce0), .o_mem_ce1(mem_ce1), .i_mem_q0(mem_q0), .i_mem_q1(mem_q1)
    );

    // BRAM macro stand-in: registered read, write on CE&WE
    always @(posedge clk) begin
        if (mem_ce0) begin
            if (mem_we0) bram[mem_a0] <= mem_d0;
            else         mem_q0 <= bram[mem_a0];
        end
        if (mem_ce1) begin
            if (mem_we1) bram[mem_a1] <= mem_d1;
            else         mem_q1 <= bram[mem_a1];
        end
    end

    // Reference: pick the first two requesters in scan order, apply the conflict rule,
    // predict next-cycle read returns from the reference memory, then commit writes.
    task automatic model_step(output logic [NREQ-1:0] eg);
        int w0, w1, idx, last;
        logic [NREQ-1:0]   nrv;
        logic [NREQ*8-1:0] nrd;
        eg = '0;
        if (rst) begin
            exp_rv = '0;
            exp_rd = '0;
            m_ptr  = 0;
            return;
        end
        w0 = -1;
        w1 = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (req[idx]) begin
                if (w0 < 0) w0 = idx;
                else if (w1 < 0) w1 = idx;
            end
        end
        if (w1 >= 0 && ra[w0] == ra[w1] && (we[w0] || we[w1])) w1 = -1;
        nrv = '0;
        nrd = '0;
        if (w0 >= 0) begin
            eg[w0] = 1'b1;
            if (!we[w0]) begin nrv[w0] = 1'b1; nrd[w0*8 +: 8] = ref_mem[ra[w0]]; end
        end
        if (w1 >= 0) begin
            eg[w1] = 1'b1;
            if (!we[w1]) begin nrv[w1] = 1'b1; nrd[w1*8 +: 8] = ref_mem[ra[w1]]; end
        end
        if (w0 >= 0 && we[w0]) ref_mem[ra[w0]] = rd[w0];
        if (w1 >= 0 && we[w1]) ref_mem[ra[w1]] = rd[w1];
`ifdef BRAM_ARB_RR_EN
        if (w0 >= 0) begin
            last  = (w1 >= 0) ? w1 : w0;
            m_ptr = (last + 1) % NREQ;
        end
`else
        last = 0;
`endif
        exp_rv = nrv;
        exp_rd = nrd;
    endtask

    task automatic reset_dut();
        logic [NREQ-1:0] eg;
        @(posedge clk); #1;
        rst = 1'b1;
        req = '0;
        we  = '0;
        model_step(eg);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [NREQ-1:0] eg;
        rst = 1'b1;
        req = '1;
        we  = '0;
        for (int i = 0; i < NREQ; i++) begin ra[i] = 11'(i); rd[i] = 8'(i); end
        @(negedge clk);
        model_step(eg);
        checks++; if (gnt !== '0) begin errors++; $display("FAIL rst_gnt: got %b want 0", gnt); end
        checks++; if (mem_ce0 !== 1'b0) begin errors++; $display("FAIL rst_ce0: got %b want 0", mem_ce0); end
        checks++; if (mem_ce1 !== 1'b0) begin errors++; $display("FAIL rst_ce1: got %b want 0", mem_ce1); end
        checks++; if (rvalid !== '0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", rvalid); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_write_read();
        logic [NREQ-1:0] eg;
        reset_dut();
        req = 4'b0100; we = 4'b0100; ra[2] = 11'h7FF; rd[2] = 8'hA5;
        @(negedge clk);
        model_step(eg);
        checks++; if (gnt[2] !== 1'b1 || gnt !== eg) begin errors++; $display("FAIL wr_gnt: got %b want %b", gnt, eg); end
        checks++; if ({mem_ce0, mem_we0, mem_a0, mem_d0} !== {1'b1, 1'b1, 11'h7FF, 8'hA5})
            begin errors++; $display("FAIL wr_port0: got ce=%b we=%b a=%h d=%h want 1 1 7ff a5", mem_ce0, mem_we0, mem_a0, mem_d0); end
        @(posedge clk); #1;
        we = 4'b0000;
        @(negedge clk);
        checks++; if (rvalid !== '0) begin errors++; $display("FAIL wr_no_rvalid: got %b want 0", rvalid); end
        model_step(eg);
        checks++; if (gnt[2] !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 0100", gnt); end
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        checks++; if (rvalid !== 4'b0100) begin errors++; $display("FAIL rd_rvalid: got %b want 0100", rvalid); end
        checks++; if (rdata[23:16] !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h want a5", rdata[23:16]); end
        model_step(eg);
    endtask

    task automatic test_dual_grant();
        logic [NREQ-1:0] eg;
        reset_dut();
        for (int i = 0; i < NREQ; i++) ra[i] = 11'(i * 16 + 1);
        we = '0;
`ifdef BRAM_ARB_RR_EN
        req = 4'b1011;
        @(negedge clk);
        model_step(eg);
        checks++; if (gnt !== 4'b0011 || gnt !== eg) begin errors++; $display("FAIL dual_c1: got %b want 0011", gnt); end
        checks++; if (mem_ce1 !== 1'b1) begin errors++; $display("FAIL dual_ce1: got %b want 1", mem_ce1); end
        @(posedge clk); #1;
        req = 4'b1000;
        @(negedge clk);
        checks++; if (rvalid !== 4'b0011 || rdata !== exp_rd) begin errors++; $display("FAIL dual_rv: got %b/%h want 0011/%h", rvalid, rdata, exp_rd); end
        model_step(eg);
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL dual_c2: got %b want 1000", gnt); end
        @(posedge clk); #1;
        req = 4'b1011;
        @(negedge clk);
        model_step(eg);
        checks++; if (gnt !== 4'b0011) begin errors++; $display("FAIL dual_c3: got %b want 0011", gnt); end
`else
        req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c > 0) begin
                checks++; if (rvalid !== 4'b0011 || rdata !== exp_rd) begin errors++; $display("FAIL fixed_rv: got %b/%h want 0011/%h", rvalid, rdata, exp_rd); end
            end
            model_step(eg);
            checks++; if (gnt !== 4'b0011 || gnt !== eg) begin errors++; $display("FAIL fixed_gnt: cycle %0d got %b want 0011", c, gnt); end
            @(posedge clk); #1;
        end
        req = '0;
`endif
    endtask

    task automatic test_conflict();
        logic [NREQ-1:0] eg;
        reset_dut();
        req = 4'b0011; we = 4'b0001; ra[0] = 11'h010; ra[1] = 11'h010; rd[0] = 8'h3C;
        @(negedge clk);
        model_step(eg);
        checks++; if (gnt !== 4'b0001 || gnt !== eg) begin errors++; $display("FAIL cf_gnt1: got %b want 0001", gnt); end
        checks++; if (mem_ce1 !== 1'b0) begin errors++; $display("FAIL cf_ce1: got %b want 0", mem_ce1); end
        @(posedge clk); #1;
        req = 4'b0010; we = '0;
        @(negedge clk);
        model_step(eg);
        checks++; if (gnt[1] !== 1'b1) begin errors++; $display("FAIL cf_gnt2: got %b want 0010", gnt); end
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        checks++; if (rvalid[1] !== 1'b1 || rdata[15:8] !== 8'h3C) begin errors++; $display("FAIL cf_rdata: got %b/%h want 1/3c", rvalid[1], rdata[15:8]); end
        model_step(eg);
    endtask

    task automatic test_reset_mid_read();
        logic [NREQ-1:0] eg;
        reset_dut();
        for (int c = 1; c < 5; c++) begin
            @(negedge clk); model_step(eg);
            @(posedge clk); #1;
        end
        req = 4'b0001; we = '0; ra[0] = 11'h010;
        @(negedge clk);
        model_step(eg);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_gnt: got %b want 0001", gnt); end
        @(posedge clk); #1;
        rst = 1'b1;
        req = '0;
        exp_rv = '0;
        exp_rd = '0;
        @(negedge clk);
        checks++; if (rvalid !== '0 || rdata !== '0) begin errors++; $display("FAIL mid_rv6: got %b/%h want 0/0", rvalid, rdata); end
        model_step(eg);
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (rvalid !== '0) begin errors++; $display("FAIL mid_rv7: got %b want 0", rvalid); end
        model_step(eg);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] upd;
        reset_dut();
        upd = '1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (upd[i]) begin
                    req[i] = ($urandom_range(0, 3) != 0);
                    we[i]  = $urandom_range(0, 1);
                    ra[i]  = ($urandom_range(0, 1) != 0) ? 11'(11'h7F8 + $urandom_range(0, 7)) : 11'($urandom_range(0, 7));
                    rd[i]  = 8'($urandom);
                end
            end
            @(negedge clk);
            checks++; if (rvalid !== exp_rv || rdata !== exp_rd) begin errors++; $display("FAIL rnd_rd: cycle %0d got %b/%h want %b/%h", c, rvalid, rdata, exp_rv, exp_rd); end
            model_step(eg);
            checks++; if (gnt !== eg) begin errors++; $display("FAIL rnd_gnt: cycle %0d got %b want %b", c, gnt, eg); end
            checks++; if (mem_ce0 !== (eg != '0) || mem_ce1 !== ($countones(eg) == 2))
                begin errors++; $display("FAIL rnd_ce: cycle %0d got %b%b for grants %b", c, mem_ce0, mem_ce1, eg); end
            upd = eg | ~req;
            @(posedge clk); #1;
        end
        req = '0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            bram[i]    = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rd[i] = '0; end
        test_reset();
        test_write_read();
        test_dual_grant();
        test_conflict();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
